// File: rtl/ibex_instr_bus_arbiter_if.sv
// Bus bundle between the prefetch buffer, the debug/loader requester and the instruction memory.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface ibex_instr_bus_arbiter_if;
   logic        pf_req_i;
   logic [31:0] pf_addr_i;
   logic        pf_gnt_o;
   logic        pf_rvalid_o;
   logic [31:0] pf_rdata_o;
   logic        pf_err_o;
   logic        dbg_req_i;
   logic [31:0] dbg_addr_i;
   logic        dbg_gnt_o;
   logic        dbg_rvalid_o;
   logic [31:0] dbg_rdata_o;
   logic        dbg_err_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        mem_err_i;
   logic        busy_o;

   modport master (
      input  pf_req_i, pf_addr_i, dbg_req_i, dbg_addr_i,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
      output pf_gnt_o, pf_rvalid_o, pf_rdata_o, pf_err_o,
      output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o,
      output mem_req_o, mem_addr_o, busy_o
   );

   modport slave (
      output pf_req_i, pf_addr_i, dbg_req_i, dbg_addr_i,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
      input  pf_gnt_o, pf_rvalid_o, pf_rdata_o, pf_err_o,
      input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o,
      input  mem_req_o, mem_addr_o, busy_o
   );
endinterface

// File: rtl/ibex_instr_bus_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between prefetch (PF) and debug (DBG),
// with a lock on the stalled winner and an in-order source FIFO that steers responses back.
module ibex_instr_bus_arbiter #(
   parameter int unsigned MaxOutstanding = 2
) (
   input logic                      clk_i,
   input logic                      rst_i,
   ibex_instr_bus_arbiter_if.master bus
);
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutstanding);

   typedef enum logic {SrcPf = 1'b0, SrcDbg = 1'b1} src_e;
   typedef enum logic {Unlocked = 1'b0, Locked = 1'b1} lock_e;

   lock_e           r_lockState;
   src_e            r_lockSrc;
   src_e            r_prio;
   logic [CntW-1:0] r_outstCnt;
   logic [PtrW-1:0] r_wrPtr;
   logic [PtrW-1:0] r_rdPtr;
   src_e            r_srcFifo [MaxOutstanding];

   src_e        w_sel;
   src_e        w_head;
   logic        w_selReq;
   logic [31:0] w_selAddr;
   logic        w_memReq;
   logic        w_grant;
   logic        w_pop;

   // A stalled winner keeps the port; otherwise a lone requester wins, and a tie goes to r_prio.
   always_comb begin
      w_sel = r_prio;
      if (r_lockState == Locked) begin
         w_sel = r_lockSrc;
      end else if (bus.pf_req_i != bus.dbg_req_i) begin
         w_sel = bus.dbg_req_i ? SrcDbg : SrcPf;
      end
   end

   assign w_selReq  = (w_sel == SrcDbg) ? bus.dbg_req_i  : bus.pf_req_i;
   assign w_selAddr = (w_sel == SrcDbg) ? bus.dbg_addr_i : bus.pf_addr_i;
   assign w_memReq  = ~rst_i & w_selReq & (r_outstCnt != FullCnt);
   assign w_grant   = w_memReq & bus.mem_gnt_i;
   assign w_pop     = ~rst_i & bus.mem_rvalid_i & (r_outstCnt != '0);
   assign w_head    = r_srcFifo[r_rdPtr];

   assign bus.mem_req_o    = w_memReq;
   assign bus.mem_addr_o   = rst_i ? 32'h0 : {w_selAddr[31:2], 2'b00};
   assign bus.pf_gnt_o     = w_grant & (w_sel == SrcPf);
   assign bus.dbg_gnt_o    = w_grant & (w_sel == SrcDbg);
   assign bus.pf_rvalid_o  = w_pop & (w_head == SrcPf);
   assign bus.dbg_rvalid_o = w_pop & (w_head == SrcDbg);
   assign bus.pf_rdata_o   = rst_i ? 32'h0 : bus.mem_rdata_i;
   assign bus.dbg_rdata_o  = rst_i ? 32'h0 : bus.mem_rdata_i;
   assign bus.pf_err_o     = ~rst_i & bus.mem_err_i;
   assign bus.dbg_err_o    = ~rst_i & bus.mem_err_i;
   assign bus.busy_o       = ~rst_i & (w_memReq | (r_outstCnt != '0));

   // Lock FSM, round-robin pointer and the outstanding-source FIFO; a dropped locked request just unlocks.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_lockState <= Unlocked;
         r_lockSrc   <= SrcPf;
         r_prio      <= SrcPf;
         r_outstCnt  <= '0;
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         for (int i = 0; i < int'(MaxOutstanding); i++) begin
            r_srcFifo[i] <= SrcPf;
         end
      end else begin
         case (r_lockState)
            Unlocked: begin
               if (w_memReq && !bus.mem_gnt_i) begin
                  r_lockState <= Locked;
                  r_lockSrc   <= w_sel;
               end
            end
            Locked: begin
               if (bus.mem_gnt_i || !w_selReq) begin
                  r_lockState <= Unlocked;
               end
            end
            default: r_lockState <= Unlocked;
         endcase

         if (w_grant) begin
            r_prio             <= (w_sel == SrcPf) ? SrcDbg : SrcPf;
            r_srcFifo[r_wrPtr] <= w_sel;
            r_wrPtr            <= (r_wrPtr == LastPtr) ? '0 : r_wrPtr + PtrW'(1);
         end

         if (w_pop) begin
            r_rdPtr <= (r_rdPtr == LastPtr) ? '0 : r_rdPtr + PtrW'(1);
         end

         if (w_grant && !w_pop) begin
            r_outstCnt <= r_outstCnt + CntW'(1);
         end else if (!w_grant && w_pop) begin
            r_outstCnt <= r_outstCnt - CntW'(1);
         end
      end
   end
endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// Bench for ibex_instr_bus_arbiter: hand-derived vector table for the directed scenarios,
// then constrained-random traffic checked against a queue-based reference model.
module tb_ibex_instr_bus_arbiter;
   localparam int MaxOut = 2;

   typedef struct {
      logic        rst;
      logic        pfReq;
      logic        dbgReq;
      logic [31:0] pfAddr;
      logic [31:0] dbgAddr;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        err;
      logic        eMemReq;
      logic [31:0] eAddr;
      logic        ePfGnt;
      logic        eDbgGnt;
      logic        ePfRv;
      logic        eDbgRv;
      logic        eBusy;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   vec_t table_q[$];

   int mQ[$];
   bit mLock;
   bit mLockSrc;
   bit mPrio;

   ibex_instr_bus_arbiter_if busIf();

   ibex_instr_bus_arbiter #(.MaxOutstanding(MaxOut)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (busIf)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic addRow(input logic r, input logic pf, input logic dbg, input logic [31:0] pfA,
                         input logic [31:0] dbgA, input logic g, input logic rv, input logic [31:0] d,
                         input logic e, input logic eReq, input logic [31:0] eA, input logic ePg,
                         input logic eDg, input logic ePr, input logic eDr, input logic eB);
      vec_t v;
      v.rst = r; v.pfReq = pf; v.dbgReq = dbg; v.pfAddr = pfA; v.dbgAddr = dbgA;
      v.gnt = g; v.rvalid = rv; v.rdata = d; v.err = e;
      v.eMemReq = eReq; v.eAddr = eA; v.ePfGnt = ePg; v.eDbgGnt = eDg;
      v.ePfRv = ePr; v.eDbgRv = eDr; v.eBusy = eB;
      table_q.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      rst                = v.rst;
      busIf.pf_req_i     = v.pfReq;
      busIf.pf_addr_i    = v.pfAddr;
      busIf.dbg_req_i    = v.dbgReq;
      busIf.dbg_addr_i   = v.dbgAddr;
      busIf.mem_gnt_i    = v.gnt;
      busIf.mem_rvalid_i = v.rvalid;
      busIf.mem_rdata_i  = v.rdata;
      busIf.mem_err_i    = v.err;
      #1;
   endtask

   task automatic compareField(input string tag, input string name, input logic [31:0] got,
                               input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s %s: got %h expected %h", tag, name, got, exp);
      end
   endtask

   task automatic checkOutput(input vec_t v, input string tag);
      logic [31:0] eData;
      logic        eErr;
      eData = v.rst ? 32'h0 : v.rdata;
      eErr  = v.rst ? 1'b0 : v.err;
      compareField(tag, "mem_req",    32'(busIf.mem_req_o),    32'(v.eMemReq));
      compareField(tag, "mem_addr",   busIf.mem_addr_o,        v.eAddr);
      compareField(tag, "pf_gnt",     32'(busIf.pf_gnt_o),     32'(v.ePfGnt));
      compareField(tag, "dbg_gnt",    32'(busIf.dbg_gnt_o),    32'(v.eDbgGnt));
      compareField(tag, "pf_rvalid",  32'(busIf.pf_rvalid_o),  32'(v.ePfRv));
      compareField(tag, "dbg_rvalid", 32'(busIf.dbg_rvalid_o), 32'(v.eDbgRv));
      compareField(tag, "pf_rdata",   busIf.pf_rdata_o,        eData);
      compareField(tag, "dbg_rdata",  busIf.dbg_rdata_o,       eData);
      compareField(tag, "pf_err",     32'(busIf.pf_err_o),     32'(eErr));
      compareField(tag, "dbg_err",    32'(busIf.dbg_err_o),    32'(eErr));
      compareField(tag, "busy",       32'(busIf.busy_o),       32'(v.eBusy));
   endtask

   // Reference model: outstanding issuers kept as a queue, lock and preference as plain flags.
   function automatic bit modelSel(input vec_t v);
      if (mLock) return mLockSrc;
      if (v.pfReq != v.dbgReq) return v.dbgReq;
      return mPrio;
   endfunction

   function automatic vec_t modelExpect(input vec_t v);
      vec_t        r;
      bit          sel;
      bit          req;
      logic [31:0] a;
      r = v;
      r.eMemReq = 0; r.eAddr = 0; r.ePfGnt = 0; r.eDbgGnt = 0;
      r.ePfRv = 0; r.eDbgRv = 0; r.eBusy = 0;
      if (v.rst) return r;
      sel = modelSel(v);
      req = sel ? v.dbgReq : v.pfReq;
      a   = sel ? v.dbgAddr : v.pfAddr;
      r.eMemReq = req && (mQ.size() < MaxOut);
      r.eAddr   = a & 32'hFFFF_FFFC;
      r.ePfGnt  = r.eMemReq && v.gnt && !sel;
      r.eDbgGnt = r.eMemReq && v.gnt && sel;
      if (v.rvalid && mQ.size() > 0) begin
         r.ePfRv  = (mQ[0] == 0);
         r.eDbgRv = (mQ[0] == 1);
      end
      r.eBusy = r.eMemReq || (mQ.size() > 0);
      return r;
   endfunction

   task automatic modelUpdate(input vec_t v);
      bit sel;
      bit req;
      bit memReq;
      if (v.rst) begin
         mQ.delete();
         mLock = 0; mLockSrc = 0; mPrio = 0;
         return;
      end
      sel    = modelSel(v);
      req    = sel ? v.dbgReq : v.pfReq;
      memReq = req && (mQ.size() < MaxOut);
      if (v.rvalid && mQ.size() > 0) void'(mQ.pop_front());
      if (memReq && v.gnt) begin
         mQ.push_back(int'(sel));
         mPrio = !sel;
      end
      if (!mLock) begin
         if (memReq && !v.gnt) begin
            mLock    = 1;
            mLockSrc = sel;
         end
      end else if (v.gnt || !req) begin
         mLock = 0;
      end
   endtask

   initial begin
      bit          pfHold;
      bit          dbgHold;
      logic [31:0] pfAddrH;
      logic [31:0] dbgAddrH;
      vec_t        v;

      clk = 0; rst = 1; checks = 0; failures = 0;
      busIf.pf_req_i = 0; busIf.pf_addr_i = 0; busIf.dbg_req_i = 0; busIf.dbg_addr_i = 0;
      busIf.mem_gnt_i = 0; busIf.mem_rvalid_i = 0; busIf.mem_rdata_i = 0; busIf.mem_err_i = 0;

      //     rst pf dbg pfAddr        dbgAddr       gnt rv rdata         err req addr          pfG dbG pfR dbR busy
      addRow(1, 1, 0, 32'h0000_1006, 32'h0,        1, 1, 32'h1111_1111, 1, 0, 32'h0,        0, 0, 0, 0, 0);
      addRow(0, 1, 0, 32'h0000_1006, 32'h0,        1, 0, 32'h0,         0, 1, 32'h0000_1004, 1, 0, 0, 0, 1);
      addRow(0, 0, 0, 32'h0,         32'h0,        0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,        0, 0, 1, 0, 1);
      addRow(0, 1, 1, 32'h100,       32'h200,      1, 0, 32'h0,         0, 1, 32'h200,      0, 1, 0, 0, 1);
      addRow(0, 1, 1, 32'h104,       32'h204,      1, 1, 32'hA4,        1, 1, 32'h104,      1, 0, 0, 1, 1);
      addRow(0, 1, 1, 32'h104,       32'h208,      1, 1, 32'hA5,        0, 1, 32'h208,      0, 1, 1, 0, 1);
      addRow(0, 0, 0, 32'h0,         32'h0,        0, 1, 32'hA6,        0, 0, 32'h0,        0, 0, 0, 1, 1);
      addRow(0, 0, 1, 32'h0,         32'h500,      0, 0, 32'h0,         0, 1, 32'h500,      0, 0, 0, 0, 1);
      addRow(0, 1, 1, 32'h400,       32'h500,      0, 0, 32'h0,         0, 1, 32'h500,      0, 0, 0, 0, 1);
      addRow(0, 1, 1, 32'h400,       32'h500,      0, 0, 32'h0,         0, 1, 32'h500,      0, 0, 0, 0, 1);
      addRow(0, 1, 1, 32'h400,       32'h500,      1, 0, 32'h0,         0, 1, 32'h500,      0, 1, 0, 0, 1);
      addRow(0, 1, 1, 32'h400,       32'h504,      1, 0, 32'h0,         0, 1, 32'h400,      1, 0, 0, 0, 1);
      addRow(0, 1, 1, 32'h408,       32'h504,      1, 0, 32'h0,         0, 0, 32'h504,      0, 0, 0, 0, 1);
      addRow(0, 1, 1, 32'h408,       32'h504,      1, 1, 32'hC3,        1, 0, 32'h504,      0, 0, 0, 1, 1);
      addRow(0, 1, 1, 32'h408,       32'h504,      1, 1, 32'hC4,        0, 1, 32'h504,      0, 1, 1, 0, 1);
      addRow(0, 0, 0, 32'h0,         32'h0,        0, 1, 32'hC5,        0, 0, 32'h0,        0, 0, 0, 1, 1);
      addRow(0, 0, 0, 32'h0,         32'h0,        0, 1, 32'hC6,        0, 0, 32'h0,        0, 0, 0, 0, 0);
      addRow(0, 1, 0, 32'h600,       32'h0,        1, 0, 32'h0,         0, 1, 32'h600,      1, 0, 0, 0, 1);
      addRow(0, 0, 1, 32'h0,         32'h700,      1, 0, 32'h0,         0, 1, 32'h700,      0, 1, 0, 0, 1);
      addRow(1, 1, 0, 32'h800,       32'h0,        1, 1, 32'hD0,        1, 0, 32'h0,        0, 0, 0, 0, 0);
      addRow(0, 0, 0, 32'h0,         32'h0,        0, 1, 32'hD1,        1, 0, 32'h0,        0, 0, 0, 0, 0);
      addRow(0, 1, 0, 32'h800,       32'h0,        0, 0, 32'h0,         0, 1, 32'h800,      0, 0, 0, 0, 1);
      addRow(0, 0, 1, 32'h0,         32'h900,      1, 0, 32'h0,         0, 0, 32'h0,        0, 0, 0, 0, 0);
      addRow(0, 0, 1, 32'h0,         32'h900,      1, 0, 32'h0,         0, 1, 32'h900,      0, 1, 0, 0, 1);
      addRow(0, 0, 0, 32'h0,         32'h0,        0, 1, 32'hE1,        0, 0, 32'h0,        0, 0, 0, 1, 1);

      $display("[TB] directed table: %0d rows", table_q.size());
      for (int i = 0; i < table_q.size(); i++) begin
         applyStimulus(table_q[i]);
         checkOutput(table_q[i], $sformatf("row%0d", i));
      end

      $display("[TB] random phase");
      pfHold = 0; dbgHold = 0; pfAddrH = 0; dbgAddrH = 0;
      v = table_q[0];
      v.rst = 1;
      v = modelExpect(v);
      applyStimulus(v);
      checkOutput(v, "rand_reset");
      modelUpdate(v);
      for (int c = 0; c < 800; c++) begin
         if (!pfHold && $urandom_range(2) == 0) begin
            pfHold  = 1;
            pfAddrH = $urandom;
         end
         if (!dbgHold && $urandom_range(2) == 0) begin
            dbgHold  = 1;
            dbgAddrH = $urandom;
         end
         v.rst     = ($urandom_range(63) == 0);
         v.pfReq   = pfHold;
         v.dbgReq  = dbgHold;
         v.pfAddr  = pfHold ? pfAddrH : $urandom;
         v.dbgAddr = dbgHold ? dbgAddrH : $urandom;
         v.gnt     = 1'($urandom_range(1));
         v.rvalid  = 1'($urandom_range(1));
         v.rdata   = $urandom;
         v.err     = 1'($urandom_range(1));
         v = modelExpect(v);
         applyStimulus(v);
         checkOutput(v, $sformatf("rand%0d", c));
         modelUpdate(v);
         if (v.ePfGnt) pfHold = 0;
         if (v.eDbgGnt) dbgHold = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
